// File: rtl/reg_native_if2apb_wide_pkg.sv
// Shared types and constants for the native-to-APB wide bridge.
package reg_apb_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam int PPROT_PRIV_BIT  = 0;
    localparam int PPROT_NS_BIT    = 1;
    localparam int PPROT_INSTR_BIT = 2;

    function automatic logic [2:0] make_pprot(input logic non_sec);
        logic [2:0] prot;
        prot               = 3'b000;
        prot[PPROT_NS_BIT] = non_sec;
        return prot;
    endfunction

endpackage

// File: rtl/reg_native_if2apb_wide_if.sv
// APB4 bus bundle between the bridge (master) and the completer (slave).
interface reg_native_if2apb_wide_if #(
    parameter int ADDR_WIDTH     = 48,
    parameter int APB_DATA_WIDTH = 32
);
    localparam int APB_BYTES = APB_DATA_WIDTH / 8;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_BYTES-1:0]      pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic                      pslverr;
    logic [APB_DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/reg_native_if2apb_wide_timeout.sv
// Per-beat wait-state counter; a zero limit keeps expired low.
module reg_apb_timeout_cnt #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    logic [CNT_W-1:0] cnt_r;

    // Wait-state count, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r < limit)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (limit != '0) && (cnt_r >= limit);
endmodule

// File: rtl/reg_native_if2apb_wide.sv
// Native register port to APB4 bridge; splits each wide access into narrow APB beats.
module reg_native_if2apb_wide
    import reg_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH          = 48,
    parameter int NATIVE_DATA_WIDTH   = 64,
    parameter int APB_DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES      = 256,
    parameter int SECURE_ACCESS_CHECK = 1
) (
    input  logic                         native_clk,
    input  logic                         native_rst_n,
    input  logic                         soft_rst,
    input  logic                         req_vld,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [NATIVE_DATA_WIDTH-1:0] wr_data,
    input  logic                         non_sec,
    output logic                         ack_vld,
    output logic [NATIVE_DATA_WIDTH-1:0] rd_data,
    output logic                         err,
    input  logic                         domain_is_non_secure,
    input  logic                         error_report_en,
    reg_native_if2apb_wide_if.master     apb
);
    localparam int BEATS        = NATIVE_DATA_WIDTH / APB_DATA_WIDTH;
    localparam int APB_BYTES    = APB_DATA_WIDTH / 8;
    localparam int NATIVE_BYTES = NATIVE_DATA_WIDTH / 8;
    localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                       state_r, state_nx;
    logic [BEAT_W-1:0]            beat_r, beat_nx;
    logic [ADDR_WIDTH-1:0]        base_r, base_nx_s, paddr_nx_s;
    logic [NATIVE_DATA_WIDTH-1:0] wdata_r, wdata_nx_s;
    logic [NATIVE_DATA_WIDTH-1:0] rd_buf_r, rd_buf_nx;
    logic [APB_DATA_WIDTH-1:0]    pwdata_nx_s;
    logic                         wr_r, rd_r, ns_r, wr_nx_s, rd_nx_s, ns_nx_s;
    logic                         accept_s, bad_s, reject_s, fail_s, timeout_s, bus_s;

    logic                         ack_vld_r, err_r, psel_r, penable_r, pwrite_r;
    logic [NATIVE_DATA_WIDTH-1:0] rd_data_r;
    logic [ADDR_WIDTH-1:0]        paddr_r;
    logic [APB_DATA_WIDTH-1:0]    pwdata_r;
    logic [APB_BYTES-1:0]         pstrb_r;
    logic [2:0]                   pprot_r;

    assign bad_s = (wr_en == rd_en) ||
                   ((SECURE_ACCESS_CHECK != 0) && non_sec && !domain_is_non_secure);

    // Request attributes seen by the next cycle: live inputs while accepting, else latched copies
    always_comb begin
        accept_s = (state_r == S_IDLE) && req_vld && !soft_rst;
        if (accept_s) begin
            base_nx_s  = addr & ~ADDR_WIDTH'(NATIVE_BYTES - 1);
            wdata_nx_s = wr_data;
            wr_nx_s    = wr_en;
            rd_nx_s    = rd_en;
            ns_nx_s    = non_sec;
        end else begin
            base_nx_s  = base_r;
            wdata_nx_s = wdata_r;
            wr_nx_s    = wr_r;
            rd_nx_s    = rd_r;
            ns_nx_s    = ns_r;
        end
    end

    // Beat address and write-data slice for the upcoming beat
    always_comb begin
        paddr_nx_s  = base_nx_s;
        pwdata_nx_s = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_nx == BEAT_W'(k)) begin
                paddr_nx_s  = base_nx_s + ADDR_WIDTH'(k * APB_BYTES);
                pwdata_nx_s = wdata_nx_s[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end else begin
                paddr_nx_s  = paddr_nx_s;
                pwdata_nx_s = pwdata_nx_s;
            end
        end
    end

    // Next state, beat sequencing and read-data reassembly
    always_comb begin
        state_nx  = state_r;
        beat_nx   = beat_r;
        rd_buf_nx = rd_buf_r;
        reject_s  = 1'b0;
        fail_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_vld) begin
                    beat_nx   = '0;
                    rd_buf_nx = '0;
                    reject_s  = bad_s;
                    state_nx  = bad_s ? S_RESP : S_SETUP;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_SETUP: state_nx = S_ACCESS;
            S_ACCESS: begin
                if (apb.pready) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (rd_r && (beat_r == BEAT_W'(k))) begin
                            rd_buf_nx[k*APB_DATA_WIDTH +: APB_DATA_WIDTH] = apb.prdata;
                        end else begin
                            rd_buf_nx = rd_buf_nx;
                        end
                    end
                    if (apb.pslverr) begin
                        fail_s   = 1'b1;
                        state_nx = S_RESP;
                    end else if (beat_r == BEAT_W'(BEATS - 1)) begin
                        state_nx = S_RESP;
                    end else begin
                        beat_nx  = beat_r + BEAT_W'(1);
                        state_nx = S_SETUP;
                    end
                end else if (timeout_s) begin
                    fail_s   = 1'b1;
                    state_nx = S_RESP;
                end else begin
                    state_nx = S_ACCESS;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (soft_rst) begin
            state_nx = S_IDLE;
            beat_nx  = '0;
        end else begin
            state_nx = state_nx;
        end
    end

    assign bus_s = (state_nx == S_SETUP) || (state_nx == S_ACCESS);

    // FSM state, beat index and read reassembly buffer
    always_ff @(posedge native_clk or negedge native_rst_n) begin
        if (!native_rst_n) begin
            state_r  <= S_IDLE;
            beat_r   <= '0;
            rd_buf_r <= '0;
        end else begin
            state_r  <= state_nx;
            beat_r   <= beat_nx;
            rd_buf_r <= rd_buf_nx;
        end
    end

    // Request attributes captured on accept
    always_ff @(posedge native_clk or negedge native_rst_n) begin
        if (!native_rst_n) begin
            base_r  <= '0;
            wdata_r <= '0;
            wr_r    <= 1'b0;
            rd_r    <= 1'b0;
            ns_r    <= 1'b0;
        end else if (accept_s) begin
            base_r  <= base_nx_s;
            wdata_r <= wdata_nx_s;
            wr_r    <= wr_nx_s;
            rd_r    <= rd_nx_s;
            ns_r    <= ns_nx_s;
        end else begin
            base_r  <= base_r;
            wdata_r <= wdata_r;
            wr_r    <= wr_r;
            rd_r    <= rd_r;
            ns_r    <= ns_r;
        end
    end

    // Registered native response and APB outputs, derived from the next state
    always_ff @(posedge native_clk or negedge native_rst_n) begin
        if (!native_rst_n) begin
            ack_vld_r <= 1'b0;
            err_r     <= 1'b0;
            rd_data_r <= '0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pstrb_r   <= '0;
            pprot_r   <= 3'b000;
        end else begin
            ack_vld_r <= (state_nx == S_RESP);
            err_r     <= (state_nx == S_RESP) && error_report_en && (reject_s || fail_s);
            rd_data_r <= ((state_nx == S_RESP) && rd_nx_s) ? rd_buf_nx : rd_data_r;
            psel_r    <= bus_s;
            penable_r <= (state_nx == S_ACCESS);
            pwrite_r  <= bus_s && wr_nx_s;
            paddr_r   <= bus_s ? paddr_nx_s : '0;
            pwdata_r  <= bus_s ? pwdata_nx_s : '0;
            pstrb_r   <= (bus_s && wr_nx_s) ? {APB_BYTES{1'b1}} : {APB_BYTES{1'b0}};
            pprot_r   <= bus_s ? make_pprot(ns_nx_s) : 3'b000;
        end
    end

    reg_apb_timeout_cnt #(.CNT_W(CNT_W)) u_timeout (
        .clk     (native_clk),
        .rst_n   (native_rst_n),
        .clr     (soft_rst || (state_r != S_ACCESS)),
        .inc     ((state_r == S_ACCESS) && !apb.pready),
        .limit   (CNT_W'(TIMEOUT_CYCLES)),
        .expired (timeout_s)
    );

    assign ack_vld     = ack_vld_r;
    assign err         = err_r;
    assign rd_data     = rd_data_r;
    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.paddr   = paddr_r;
    assign apb.pwdata  = pwdata_r;
    assign apb.pstrb   = pstrb_r;
    assign apb.pprot   = pprot_r;
endmodule

// File: tb/tb_reg_native_if2apb_wide.sv
// Directed bench for reg_native_if2apb_wide with a 4-cycle timeout.
module tb_reg_native_if2apb_wide;
    logic        native_clk = 1'b0;
    logic        native_rst_n, soft_rst, req_vld, wr_en, rd_en, non_sec;
    logic [47:0] addr;
    logic [63:0] wr_data, rd_data;
    logic        ack_vld, err, domain_is_non_secure, error_report_en;
    int          n_tests = 0;
    int          n_fail  = 0;

    reg_native_if2apb_wide_if #(.ADDR_WIDTH(48), .APB_DATA_WIDTH(32)) apb_if ();

    reg_native_if2apb_wide #(
        .ADDR_WIDTH(48), .NATIVE_DATA_WIDTH(64), .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4), .SECURE_ACCESS_CHECK(1)
    ) dut (
        .native_clk(native_clk), .native_rst_n(native_rst_n), .soft_rst(soft_rst),
        .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .non_sec(non_sec), .ack_vld(ack_vld), .rd_data(rd_data),
        .err(err), .domain_is_non_secure(domain_is_non_secure),
        .error_report_en(error_report_en), .apb(apb_if)
    );

    always #5 native_clk = ~native_clk;

    task automatic tick();
        @(posedge native_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request; returns positioned in cycle 1
    task automatic issue(input logic w, input logic r, input logic [47:0] a,
                         input logic [63:0] d, input logic ns);
        req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d; non_sec = ns;
        tick();
        req_vld = 1'b0;
    endtask

    initial begin
        native_rst_n = 1'b0; soft_rst = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = 48'h0; wr_data = 64'h0; non_sec = 1'b0;
        domain_is_non_secure = 1'b1; error_report_en = 1'b1;
        apb_if.pready = 1'b1; apb_if.pslverr = 1'b0; apb_if.prdata = 32'h0;
        tick(); tick();
        chk("rst_ack",   64'(ack_vld), 64'd0);
        chk("rst_psel",  64'(apb_if.psel), 64'd0);
        chk("rst_pen",   64'(apb_if.penable), 64'd0);
        chk("rst_paddr", 64'(apb_if.paddr), 64'd0);
        chk("rst_pstrb", 64'(apb_if.pstrb), 64'd0);
        chk("rst_pprot", 64'(apb_if.pprot), 64'd0);
        chk("rst_rdata", rd_data, 64'd0);
        chk("rst_err",   64'(err), 64'd0);
        native_rst_n = 1'b1;
        tick();

        // 64-bit write, zero wait
        issue(1'b1, 1'b0, 48'h1004, 64'hAABBCCDD_11223344, 1'b0);
        chk("wr_c1_psel",   64'(apb_if.psel), 64'd1);
        chk("wr_c1_pen",    64'(apb_if.penable), 64'd0);
        chk("wr_c1_paddr",  64'(apb_if.paddr), 64'h1000);
        chk("wr_c1_pwdata", 64'(apb_if.pwdata), 64'h11223344);
        chk("wr_c1_pstrb",  64'(apb_if.pstrb), 64'hF);
        chk("wr_c1_pwrite", 64'(apb_if.pwrite), 64'd1);
        tick();
        chk("wr_c2_pen",    64'(apb_if.penable), 64'd1);
        chk("wr_c2_paddr",  64'(apb_if.paddr), 64'h1000);
        tick();
        chk("wr_c3_psel",   64'(apb_if.psel), 64'd1);
        chk("wr_c3_pen",    64'(apb_if.penable), 64'd0);
        chk("wr_c3_paddr",  64'(apb_if.paddr), 64'h1004);
        chk("wr_c3_pwdata", 64'(apb_if.pwdata), 64'hAABBCCDD);
        tick();
        chk("wr_c4_pen",    64'(apb_if.penable), 64'd1);
        chk("wr_c4_ack",    64'(ack_vld), 64'd0);
        tick();
        chk("wr_c5_ack",    64'(ack_vld), 64'd1);
        chk("wr_c5_err",    64'(err), 64'd0);
        chk("wr_c5_psel",   64'(apb_if.psel), 64'd0);
        // request during RESP must be ignored
        req_vld = 1'b1; wr_en = 1'b1; rd_en = 1'b0;
        tick();
        req_vld = 1'b0;
        chk("resp_req_ack",   64'(ack_vld), 64'd0);
        chk("resp_req_psel1", 64'(apb_if.psel), 64'd0);
        tick();
        chk("resp_req_psel2", 64'(apb_if.psel), 64'd0);

        // 64-bit read with two wait states on beat 0
        apb_if.pready = 1'b0;
        issue(1'b0, 1'b1, 48'h2000, 64'h0, 1'b0);
        chk("rd_c1_pstrb",  64'(apb_if.pstrb), 64'd0);
        chk("rd_c1_pwrite", 64'(apb_if.pwrite), 64'd0);
        tick();
        chk("rd_c2_pen", 64'(apb_if.penable), 64'd1);
        tick();
        chk("rd_c3_pen", 64'(apb_if.penable), 64'd1);
        tick();
        apb_if.pready = 1'b1; apb_if.prdata = 32'h1;
        chk("rd_c4_paddr", 64'(apb_if.paddr), 64'h2000);
        tick();
        apb_if.prdata = 32'h2;
        chk("rd_c5_pen",   64'(apb_if.penable), 64'd0);
        chk("rd_c5_paddr", 64'(apb_if.paddr), 64'h2004);
        tick();
        chk("rd_c6_ack",   64'(ack_vld), 64'd0);
        chk("rd_c6_hold",  rd_data, 64'd0);
        tick();
        chk("rd_c7_ack",   64'(ack_vld), 64'd1);
        chk("rd_c7_rdata", rd_data, 64'h00000002_00000001);
        chk("rd_c7_err",   64'(err), 64'd0);
        tick();

        // pslverr on beat 0 of a write
        apb_if.pslverr = 1'b1;
        issue(1'b1, 1'b0, 48'h3000, 64'h01234567_89ABCDEF, 1'b0);
        tick(); tick();
        chk("slv_ack",   64'(ack_vld), 64'd1);
        chk("slv_err",   64'(err), 64'd1);
        chk("slv_rhold", rd_data, 64'h00000002_00000001);
        tick();
        chk("slv_nobeat1", 64'(apb_if.psel), 64'd0);
        error_report_en = 1'b0;
        issue(1'b1, 1'b0, 48'h3000, 64'h01234567_89ABCDEF, 1'b0);
        tick(); tick();
        chk("slv_masked_ack", 64'(ack_vld), 64'd1);
        chk("slv_masked_err", 64'(err), 64'd0);
        error_report_en = 1'b1; apb_if.pslverr = 1'b0;
        tick();

        // timeout after 4 wait states
        apb_if.pready = 1'b0;
        issue(1'b0, 1'b1, 48'h4000, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("to_c6_psel", 64'(apb_if.psel), 64'd1);
        chk("to_c6_ack",  64'(ack_vld), 64'd0);
        tick();
        chk("to_c7_psel",  64'(apb_if.psel), 64'd0);
        chk("to_c7_ack",   64'(ack_vld), 64'd1);
        chk("to_c7_err",   64'(err), 64'd1);
        chk("to_c7_rdata", rd_data, 64'd0);
        apb_if.pready = 1'b1; apb_if.prdata = 32'h55;
        tick();
        issue(1'b0, 1'b1, 48'h5000, 64'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("to_next_ack",   64'(ack_vld), 64'd1);
        chk("to_next_rdata", rd_data, 64'h00000055_00000055);
        chk("to_next_err",   64'(err), 64'd0);
        tick();

        // non-secure request into a secure domain
        domain_is_non_secure = 1'b0;
        issue(1'b0, 1'b1, 48'h6000, 64'h0, 1'b1);
        chk("sec_psel",  64'(apb_if.psel), 64'd0);
        chk("sec_ack",   64'(ack_vld), 64'd1);
        chk("sec_err",   64'(err), 64'd1);
        chk("sec_rdata", rd_data, 64'd0);
        tick();
        chk("sec_ack_c2", 64'(ack_vld), 64'd0);
        domain_is_non_secure = 1'b1; apb_if.prdata = 32'h77;
        issue(1'b0, 1'b1, 48'h6008, 64'h0, 1'b1);
        chk("ns_pprot", 64'(apb_if.pprot), 64'd2);
        chk("ns_psel",  64'(apb_if.psel), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("ns_ack",   64'(ack_vld), 64'd1);
        chk("ns_rdata", rd_data, 64'h00000077_00000077);
        tick();

        // asynchronous reset mid-beat
        issue(1'b1, 1'b0, 48'h7000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        tick();
        native_rst_n = 1'b0;
        #1;
        chk("arst_psel",   64'(apb_if.psel), 64'd0);
        chk("arst_pen",    64'(apb_if.penable), 64'd0);
        chk("arst_pwdata", 64'(apb_if.pwdata), 64'd0);
        chk("arst_pstrb",  64'(apb_if.pstrb), 64'd0);
        chk("arst_pprot",  64'(apb_if.pprot), 64'd0);
        chk("arst_rdata",  rd_data, 64'd0);
        tick();
        native_rst_n = 1'b1;
        tick();
        chk("arst_noack", 64'(ack_vld), 64'd0);

        // soft reset coincident with pready in ACCESS
        apb_if.pready = 1'b0;
        issue(1'b1, 1'b0, 48'h8000, 64'h1, 1'b0);
        tick();
        soft_rst = 1'b1; apb_if.pready = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("srst_psel", 64'(apb_if.psel), 64'd0);
        chk("srst_pen",  64'(apb_if.penable), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("srst_noack", 64'(ack_vld), 64'd0);
            tick();
        end

        // wr_en and rd_en both set
        issue(1'b1, 1'b1, 48'h9000, 64'h0, 1'b0);
        chk("both_ack",  64'(ack_vld), 64'd1);
        chk("both_err",  64'(err), 64'd1);
        chk("both_psel", 64'(apb_if.psel), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_native_if2apb_wide.md
# reg_native_if2apb_wide

Single-clock bridge from the register native interface to an APB4 completer port. It supports a native data path wider than the APB data path: each native access is split into sequential APB beats, and read data is reassembled. It adds a per-beat wait-state timeout, early abort on `pslverr`, and a secure-access check. It sits between a reg-block native port and a narrow APB peripheral slice running on the same clock.

## Interface
- `ADDR_WIDTH`, 48, native/APB address width.
- `NATIVE_DATA_WIDTH`, 64, native data width; must be an integer multiple (≥1) of `APB_DATA_WIDTH`.
- `APB_DATA_WIDTH`, 32, APB data width (8/16/32).
- `TIMEOUT_CYCLES`, 256, max wait states per beat; 0 disables the timeout.
- `SECURE_ACCESS_CHECK`, 1, enables non-secure rejection.
- Derived values: `BEATS = NATIVE_DATA_WIDTH/APB_DATA_WIDTH`, `APB_BYTES = APB_DATA_WIDTH/8`.
- Clock and reset (fixed): one clock; reset is asynchronous and active-low.
- `native_clk  in  1`  sole clock; the APB side runs on this same clock.
- `native_rst_n  in  1`  asynchronous active-low reset.
- `soft_rst  in  1`  synchronous abort of the in-flight access.
- `req_vld  in  1`  request pulse.
- `wr_en  in  1`  write request.
- `rd_en  in  1`  read request.
- `addr  in  ADDR_WIDTH`  byte address.
- `wr_data  in  NATIVE_DATA_WIDTH`  write data.
- `non_sec  in  1`  request is non-secure.
- `ack_vld  out  1`  one-cycle completion pulse.
- `rd_data  out  NATIVE_DATA_WIDTH`  assembled read data.
- `err  out  1`  error, valid with `ack_vld`.
- `psel, penable, pwrite  out  1`  APB control.
- `paddr  out  ADDR_WIDTH`  APB address.
- `pwdata  out  APB_DATA_WIDTH`  APB write data.
- `pstrb  out  APB_BYTES`  APB write strobes.
- `pprot  out  3`  protection: `{1'b0, non_sec, 1'b0}`.
- `pready, pslverr  in  1`  completer response.
- `prdata  in  APB_DATA_WIDTH`  completer read data.
- `domain_is_non_secure  in  1`  when 0, non-secure requests are rejected.
- `error_report_en  in  1`  when 0, `err` is forced to 0.

## Operation
- **States:** IDLE, SETUP, ACCESS, RESP.
- **Accept:** `req_vld` is accepted only in IDLE. `addr`, `wr_en`, `wr_data` and `non_sec` are latched. `req_vld` outside IDLE is ignored and never acked.
- **Reject:** the request goes IDLE→RESP with no APB activity when either holds:
  - `wr_en == rd_en`, or
  - `SECURE_ACCESS_CHECK` is set, `non_sec` = 1 and `domain_is_non_secure` = 0.
  
  A rejected read returns `rd_data` = 0.
- **Beats:** beat k = 0..BEATS-1 runs in order.
  - `paddr` = addr aligned down to NATIVE_DATA_WIDTH/8, plus k·APB_BYTES.
  - `pwdata` = `wr_data` slice k.
  - `pstrb` = all-ones on write, 0 on read.
  - Read: `prdata` is captured into slice k when `pready` = 1.
- **Transitions:**
  - IDLE→SETUP on a valid accept.
  - SETUP→ACCESS unconditionally.
  - ACCESS→SETUP on `pready` when beats remain and `pslverr` = 0.
  - ACCESS→RESP on `pready` at the last beat, on `pready & pslverr` (remaining beats skipped), or on timeout.
  - RESP→IDLE unconditionally.
- **Timeout:** a counter increments each ACCESS cycle with `pready` = 0 and clears in SETUP. When it reaches `TIMEOUT_CYCLES`, `psel`/`penable` are dropped and the FSM goes to RESP.
- **Error:** `err` = `error_report_en` & (reject | `pslverr` | timeout).
- **rd_data:** updated in RESP for reads only (unreceived slices are 0) and held otherwise.
- **soft_rst:** forces IDLE the next cycle; APB outputs drop to 0; no ack is issued; counters are cleared.

## Timing
- All outputs are registered.
- **Reset values:** every output is 0, including `rd_data` and `pstrb`.
- **Zero-wait access:** `req_vld` at cycle 0 produces:
  - SETUP (`psel`=1, `penable`=0) at cycle 1,
  - ACCESS (`penable`=1) at cycle 2,
  - the next beat's SETUP at cycle 3,
  - `ack_vld` at cycle 2·BEATS+1.
- **With wait states:** each wait state adds one cycle.
- **Reject:** `ack_vld` at cycle 1.
- `psel` stays high across back-to-back beats within one access; `penable` is low for exactly one cycle per beat.
- `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot` are stable from SETUP through the end of ACCESS.
- **Timeout:** fires at the ACCESS cycle where TIMEOUT_CYCLES wait states have elapsed; `ack_vld` follows one cycle later.
- **Boundaries:**
  - `native_rst_n` low mid-beat clears everything asynchronously.
  - `soft_rst` coincident with `pready` drops the beat (no ack).
  - `req_vld` in the RESP cycle is ignored.

## Structure
- Package `reg_apb_bridge_pkg` holds the state enum (`S_IDLE`/`S_SETUP`/`S_ACCESS`/`S_RESP`) and the `pprot` bit-position constants.
- Sub-module `reg_apb_timeout_cnt` holds the counter, with inputs `clr`, `inc` and `limit`, and output `expired`. `TIMEOUT_CYCLES` = 0 ties `expired` low.

## Test plan
- **64-bit write, zero wait:** `addr` 0x1004, `wr_data` 0xAABBCCDD_11223344 → beats at 0x1000 with `pwdata` 0x11223344 and 0x1004 with 0xAABBCCDD; `pstrb` 0xF; `ack_vld` at cycle 5; `err` 0.
- **64-bit read with waits:** `prdata` 0x1 (2 waits), then 0x2 → `rd_data` 0x00000002_00000001; `ack_vld` at cycle 7.
- **pslverr on beat 0 of a write:** beat 1 is never issued; `err` = 1, or 0 when `error_report_en` = 0.
- **Timeout:** `TIMEOUT_CYCLES` = 4 and `pready` held low → `psel` drops after 4 waits; `err` = 1; the next request proceeds normally.
- **Security:** `non_sec` = 1 with `domain_is_non_secure` = 0 → no `psel`; `ack_vld` at cycle 1; `err` = 1. With `non_sec` = 1 and `domain_is_non_secure` = 1 → `pprot` = 3'b010.
- **soft_rst in ACCESS, and `wr_en` & `rd_en` both set:** first case → `psel` 0 the next cycle and no ack. Second case → reject with `err` = 1.
